heap_pq: RTL

HEAP_PQ -- requirements
Module: heap_pq

---
 rtl/heap_pkg.sv | 18 +
 rtl/heap_cmp.sv | 14 +
 rtl/heap_pq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/heap_pkg.sv
// Shared opcode and FSM state encodings for the binary-heap priority queue.
package heap_pkg;

  typedef enum logic [1:0] {
    NOP     = 2'b00,
    PUSH    = 2'b01,
    POP     = 2'b10,
    REPLACE = 2'b11
  } heap_op_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SIFT_UP   = 2'b01,
    SIFT_DOWN = 2'b10,
    FIN       = 2'b11
  } heap_state_e;

endpackage

// File: rtl/heap_cmp.sv
// Strict "better" comparator: a_i beats b_i only when strictly smaller (min-heap)
// or strictly larger (max-heap), so equal keys never trigger a swap.
module heap_cmp #(
  parameter int KEY_W    = 32,
  parameter bit MIN_HEAP = 1'b1
) (
  input  logic [KEY_W-1:0] a_i,
  input  logic [KEY_W-1:0] b_i,
  output logic             better_o
);

  assign better_o = MIN_HEAP ? (a_i < b_i) : (a_i > b_i);

endmodule

// File: rtl/heap_pq.sv
// Binary-heap priority queue, one sift level per cycle, PUSH/POP/REPLACE commands.
// Define HEAP_STATS_EN to add the peak_n and err_cnt statistics ports.
module heap_pq
  import heap_pkg::*;
#(
  parameter int KEY_W    = 32,
  parameter int ADDR_W   = 10,
  parameter bit MIN_HEAP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        instruction,
  input  logic [KEY_W-1:0]  key,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [KEY_W-1:0]  arr_out,
  output logic [ADDR_W-1:0] n,
  output logic              full,
  output logic              empty,
  output heap_state_e       state
`ifdef HEAP_STATS_EN
  ,
  output logic [ADDR_W-1:0] peak_n,
  output logic [15:0]       err_cnt
`endif
);

  localparam int                MEM_TOP  = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] CAP_N    = '1;
  localparam logic [ADDR_W-1:0] IDX_ROOT = ADDR_W'(1);

  heap_state_e       state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic              perr_q, perr_d;
  logic              done_q, err_q, full_q, empty_q;

  // Slot 0 is never used so any ADDR_W-bit index stays inside the array.
  logic [KEY_W-1:0]  mem_q [0:MEM_TOP];

  logic              wa_en, wb_en;
  logic [ADDR_W-1:0] wa_addr, wb_addr;
  logic [KEY_W-1:0]  wa_data, wb_data;

  logic [ADDR_W-1:0] par_idx, child_idx;
  logic [ADDR_W:0]   left_w, right_w;
  logic              left_in, right_in, pick_right;
  logic [KEY_W-1:0]  cur_key, par_key, left_key, right_key, child_key;
  logic              up_better, right_better, child_better;

  assign cur_key   = mem_q[cur_q];
  assign par_idx   = cur_q >> 1;
  assign par_key   = mem_q[par_idx];
  assign left_w    = {cur_q, 1'b0};
  assign right_w   = {cur_q, 1'b1};
  assign left_in   = (left_w <= {1'b0, n_q});
  assign right_in  = (right_w <= {1'b0, n_q});
  assign left_key  = mem_q[left_w[ADDR_W-1:0]];
  assign right_key = mem_q[right_w[ADDR_W-1:0]];

  // Right child wins only when strictly better, so the left one takes ties.
  assign pick_right = right_in && right_better;
  assign child_idx  = pick_right ? right_w[ADDR_W-1:0] : left_w[ADDR_W-1:0];
  assign child_key  = pick_right ? right_key : left_key;

  heap_cmp #(.KEY_W(KEY_W), .MIN_HEAP(MIN_HEAP)) u_cmp_up (
    .a_i(cur_key), .b_i(par_key), .better_o(up_better)
  );

  heap_cmp #(.KEY_W(KEY_W), .MIN_HEAP(MIN_HEAP)) u_cmp_lr (
    .a_i(right_key), .b_i(left_key), .better_o(right_better)
  );

  heap_cmp #(.KEY_W(KEY_W), .MIN_HEAP(MIN_HEAP)) u_cmp_dn (
    .a_i(child_key), .b_i(cur_key), .better_o(child_better)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d = state_q;
    n_d     = n_q;
    cur_d   = cur_q;
    perr_d  = perr_q;
    wa_en   = 1'b0;
    wa_addr = cur_q;
    wa_data = cur_key;
    wb_en   = 1'b0;
    wb_addr = par_idx;
    wb_data = cur_key;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          perr_d = 1'b0;
          unique case (heap_op_e'(instruction))
            PUSH: begin
              if (full_q) begin
                perr_d  = 1'b1;
                state_d = FIN;
              end else begin
                wa_en   = 1'b1;
                wa_addr = n_q + IDX_ROOT;
                wa_data = key;
                n_d     = n_q + IDX_ROOT;
                cur_d   = n_q + IDX_ROOT;
                state_d = SIFT_UP;
              end
            end
            POP: begin
              if (empty_q) begin
                perr_d  = 1'b1;
                state_d = FIN;
              end else begin
                wa_en   = 1'b1;
                wa_addr = IDX_ROOT;
                wa_data = mem_q[n_q];
                n_d     = n_q - IDX_ROOT;
                cur_d   = IDX_ROOT;
                state_d = SIFT_DOWN;
              end
            end
            REPLACE: begin
              if (empty_q) begin
                perr_d  = 1'b1;
                state_d = FIN;
              end else begin
                wa_en   = 1'b1;
                wa_addr = IDX_ROOT;
                wa_data = key;
                cur_d   = IDX_ROOT;
                state_d = SIFT_DOWN;
              end
            end
            default: state_d = FIN;
          endcase
        end
      end

      SIFT_UP: begin
        if (cur_q > IDX_ROOT && up_better) begin
          wa_en   = 1'b1;
          wa_addr = cur_q;
          wa_data = par_key;
          wb_en   = 1'b1;
          wb_addr = par_idx;
          wb_data = cur_key;
          cur_d   = par_idx;
        end else begin
          state_d = FIN;
        end
      end

      SIFT_DOWN: begin
        if (left_in && child_better) begin
          wa_en   = 1'b1;
          wa_addr = cur_q;
          wa_data = child_key;
          wb_en   = 1'b1;
          wb_addr = child_idx;
          wb_data = cur_key;
          cur_d   = child_idx;
        end else begin
          state_d = FIN;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      cur_q   <= IDX_ROOT;
      perr_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cur_q   <= cur_d;
      perr_q  <= perr_d;
      done_q  <= (state_q == FIN);
      err_q   <= (state_q == FIN) && perr_q;
      full_q  <= (n_d == CAP_N);
      empty_q <= (n_d == '0);
    end
  end

  // NOTE: key storage is deliberately not reset; n=0 already marks it empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wa_en) mem_q[wa_addr] <= wa_data;
      if (wb_en) mem_q[wb_addr] <= wb_data;
    end
  end

  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);
  assign arr_out = empty_q ? '0 : mem_q[IDX_ROOT];
  assign n       = n_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign state   = state_q;

`ifdef HEAP_STATS_EN
  logic [ADDR_W-1:0] peak_q;
  logic [15:0]       err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      if (n_d > peak_q) peak_q <= n_d;
      if (err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign peak_n  = peak_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule
